// File: rtl/wb_host_master_pkg.sv
// Shared types and bus constants for the Wishbone host master.
// The address step helper keeps the beat-increment rule in one place.
package wb_host_pkg;

  localparam int WB_ADR_W    = 32;
  localparam int WB_DAT_W    = 32;
  localparam int WB_SEL_W    = 4;
  localparam int WB_ADR_STEP = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WD = 2'd1,
    STROBE  = 2'd2,
    RESP    = 2'd3
  } wbh_state_e;

  // Wraps naturally at 2^32 because the result is truncated to the bus width.
  function automatic logic [WB_ADR_W-1:0] next_beat_adr(input logic [WB_ADR_W-1:0] adr);
    return adr + 32'(WB_ADR_STEP);
  endfunction

endpackage

// File: rtl/wb_host_master_if.sv
// Wishbone classic bus bundle between the host master and the user-area slave.
// Signal names follow the master's point of view.
interface wb_host_master_if;
  import wb_host_pkg::*;

  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_o;
  logic [WB_SEL_W-1:0] wbm_sel_o;
  logic                wbm_ack_i;
  logic [WB_DAT_W-1:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/wb_host_master_timeout.sv
// Saturating ack-timeout counter. hit_o flags the cycle in which the count
// of strobe cycles reaches TIMEOUT_CYCLES, so stb is high exactly that long.
module wbm_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: clear outside the strobe phase, otherwise count up and stick at the limit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 16'd0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = en_i && !clr_i && (count_q >= (LIMIT - 16'd1));

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic-cycle initiator: turns burst commands into single-beat
// transfers with incrementing addresses and one response per beat.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_W          = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic [LEN_W-1:0]    cmd_len,

  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [WB_DAT_W-1:0] wd_data,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic                rsp_last,

  output logic                busy,

  wb_host_master_if.master    wbm
);

  wbh_state_e          state_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic [LEN_W-1:0]    beats_left_q;
  logic                wd_ready_q;
  logic                rsp_valid_q;
  logic [WB_DAT_W-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic                rsp_last_q;
  logic                to_hit_s;
  logic                last_beat_s;

  assign last_beat_s = (beats_left_q == {LEN_W{1'b0}});

  wbm_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (state_q != STROBE),
    .en_i   (stb_q),
    .hit_o  (to_hit_s)
  );

  // Burst sequencer; every bus and handshake output comes straight from a register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= {WB_ADR_W{1'b0}};
      dat_q        <= {WB_DAT_W{1'b0}};
      sel_q        <= {WB_SEL_W{1'b0}};
      beats_left_q <= {LEN_W{1'b0}};
      wd_ready_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= {WB_DAT_W{1'b0}};
      rsp_err_q    <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      wd_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            cyc_q        <= 1'b1;
            we_q         <= cmd_we;
            adr_q        <= cmd_adr;
            sel_q        <= cmd_sel;
            beats_left_q <= cmd_len;
            if (cmd_we) begin
              state_q <= WAIT_WD;
            end else begin
              stb_q   <= 1'b1;
              state_q <= STROBE;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        WAIT_WD: begin
          if (wd_valid) begin
            dat_q   <= wd_data;
            stb_q   <= 1'b1;
            state_q <= STROBE;
          end else begin
            state_q <= WAIT_WD;
          end
        end

        // Ack is checked before the timeout so a last-moment ack still succeeds.
        STROBE: begin
          if (wbm.wbm_ack_i) begin
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= last_beat_s;
            rsp_data_q  <= we_q ? {WB_DAT_W{1'b0}} : wbm.wbm_dat_i;
            wd_ready_q  <= we_q;
            state_q     <= RESP;
          end else if (to_hit_s) begin
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_last_q  <= 1'b1;
            rsp_data_q  <= {WB_DAT_W{1'b0}};
            state_q     <= RESP;
          end else begin
            state_q <= STROBE;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= {WB_DAT_W{1'b0}};
            if (rsp_last_q) begin
              cyc_q       <= 1'b0;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              adr_q        <= next_beat_adr(adr_q);
              beats_left_q <= beats_left_q - {{(LEN_W-1){1'b0}}, 1'b1};
              if (we_q) begin
                state_q <= WAIT_WD;
              end else begin
                stb_q   <= 1'b1;
                state_q <= STROBE;
              end
            end
          end else begin
            state_q <= RESP;
          end
        end

        default: begin
          state_q     <= IDLE;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign wd_ready      = wd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_last      = rsp_last_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with a registered-ack slave model whose
// wait states are adjustable; slave read data is adr ^ 0x0000FFFF.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic [3:0]  cmd_len = 4'h0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  wb_host_master_if bus ();

  wb_host_master #(.TIMEOUT_CYCLES(8), .LEN_W(4)) dut (
    .wb_clk_i (clk),       .wb_rst_ni (rst_n),
    .cmd_valid(cmd_valid), .cmd_ready (cmd_ready), .cmd_we (cmd_we),
    .cmd_adr  (cmd_adr),   .cmd_sel   (cmd_sel),   .cmd_len(cmd_len),
    .wd_valid (wd_valid),  .wd_ready  (wd_ready),  .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready (rsp_ready), .rsp_data(rsp_data),
    .rsp_err  (rsp_err),   .rsp_last  (rsp_last),  .busy   (busy),
    .wbm      (bus)
  );

  always #5 clk = ~clk;

  // Slave model: acks after sl_delay extra strobe cycles, registered ack.
  int sl_delay = 0;
  bit sl_en    = 1'b1;
  int sl_cnt   = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_dat_i <= 32'h0;
      sl_cnt        <= 0;
    end else if (sl_en && bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) begin
      if (sl_cnt >= sl_delay) begin
        bus.wbm_ack_i <= 1'b1;
        bus.wbm_dat_i <= bus.wbm_adr_o ^ 32'h0000FFFF;
        sl_cnt        <= 0;
      end else begin
        sl_cnt <= sl_cnt + 1;
      end
    end else begin
      bus.wbm_ack_i <= 1'b0;
      sl_cnt        <= 0;
    end
  end

  // Log every acknowledged beat.
  logic [31:0] mon_adr [0:255];
  logic [31:0] mon_dat [0:255];
  int mon_n = 0;
  always @(posedge clk) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
      mon_adr[mon_n[7:0]] <= bus.wbm_adr_o;
      mon_dat[mon_n[7:0]] <= bus.wbm_dat_o;
      mon_n <= mon_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    if (cmd_ready) begin
      ok        = 1'b1;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_sel   = 4'hF;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, rsp_valid, busy, cmd_ready, wd_ready} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.wbm_cyc_o, bus.wbm_stb_o, rsp_valid, busy, cmd_ready, wd_ready}); else n_pass++;
    n_checks++; if (bus.wbm_adr_o !== 32'h0) $display("FAIL reset_adr: got %h expected 0", bus.wbm_adr_o); else n_pass++;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_single_write();
    bit ok;
    int base = mon_n;
    int wdc = 0;
    sl_delay = 2;
    rsp_ready = 1'b0;
    issue_cmd(1'b1, 32'h3000_0004, 4'd0, ok);
    n_checks++; if (!ok) $display("FAIL wr_accept: got no cmd_ready expected accept"); else n_pass++;
    n_checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o} !== 2'b10) $display("FAIL wr_wait_wd: got cyc/stb %b expected 10", {bus.wbm_cyc_o, bus.wbm_stb_o}); else n_pass++;
    wd_valid = 1'b1;
    wd_data  = 32'hDEAD_BEEF;
    tick();
    wd_valid = 1'b0;
    n_checks++; if ({bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o} !== {2'b11, 32'h3000_0004, 32'hDEAD_BEEF})
      $display("FAIL wr_strobe: got stb=%b we=%b adr=%h dat=%h expected 1 1 30000004 deadbeef",
               bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wd_ready) wdc++;
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++; if (!ok) $display("FAIL wr_rsp_wait: got timeout expected rsp_valid"); else n_pass++;
    n_checks++; if ({rsp_err, rsp_last, rsp_data, bus.wbm_cyc_o} !== {2'b01, 32'h0, 1'b1})
      $display("FAIL wr_rsp: got err=%b last=%b data=%h cyc=%b expected 0 1 0 1", rsp_err, rsp_last, rsp_data, bus.wbm_cyc_o); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (wd_ready) wdc++;
    n_checks++; if ({bus.wbm_cyc_o, rsp_valid, busy} !== 3'b000) $display("FAIL wr_done: got cyc/rsp_valid/busy %b expected 000", {bus.wbm_cyc_o, rsp_valid, busy}); else n_pass++;
    n_checks++; if (wdc !== 1) $display("FAIL wr_wd_ready_pulses: got %0d expected 1", wdc); else n_pass++;
    n_checks++; if ((mon_n - base) !== 1 || mon_dat[base[7:0]] !== 32'hDEAD_BEEF)
      $display("FAIL wr_beats: got %0d beats dat=%h expected 1 deadbeef", mon_n - base, mon_dat[base[7:0]]); else n_pass++;
  endtask

  task automatic test_read_burst();
    bit ok;
    int base = mon_n;
    int s = 1;
    int nr = 0;
    bit cyc_gap = 1'b0;
    logic [31:0] rd [0:3];
    logic        rl [0:3];
    int          rs [0:3];
    logic [31:0] exp_d [0:3];
    exp_d[0] = 32'h3000_FFEF; exp_d[1] = 32'h3000_FFEB;
    exp_d[2] = 32'h3000_FFE7; exp_d[3] = 32'h3000_FFE3;
    sl_delay  = 0;
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'h3000_0010, 4'd3, ok);
    n_checks++; if (!ok) $display("FAIL rd_accept: got no cmd_ready expected accept"); else n_pass++;
    while (busy && s < 60) begin
      if (!bus.wbm_cyc_o) cyc_gap = 1'b1;
      if (rsp_valid && nr < 4) begin
        rd[nr] = rsp_data; rl[nr] = rsp_last; rs[nr] = s; nr++;
      end
      tick();
      s++;
    end
    rsp_ready = 1'b0;
    n_checks++; if (nr !== 4 || cyc_gap) $display("FAIL rd_count: got %0d rsps cyc_gap=%b expected 4 0", nr, cyc_gap); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rd[k] !== exp_d[k] || rl[k] !== (k == 3))
        $display("FAIL rd_beat%0d: got data=%h last=%b expected %h %b", k, rd[k], rl[k], exp_d[k], (k == 3)); else n_pass++;
      n_checks++; if (mon_adr[8'(base + k)] !== 32'h3000_0010 + 32'(4 * k))
        $display("FAIL rd_adr%0d: got %h expected %h", k, mon_adr[8'(base + k)], 32'h3000_0010 + 32'(4 * k)); else n_pass++;
    end
    n_checks++; if (rs[0] !== 3 || (rs[3] - rs[0]) !== 9)
      $display("FAIL rd_latency: got first=%0d span=%0d expected 3 9", rs[0], rs[3] - rs[0]); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit hold_ok = 1'b1;
    sl_delay  = 0;
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 32'h3000_0100, 4'd1, ok);
    wait_rsp(30, ok);
    n_checks++; if (!ok || rsp_data !== 32'h3000_FEFF) $display("FAIL bp_rsp0: got ok=%b data=%h expected 1 3000feff", ok, rsp_data); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.wbm_stb_o || !bus.wbm_cyc_o || !rsp_valid || rsp_data !== 32'h3000_FEFF) hold_ok = 1'b0;
    end
    n_checks++; if (!hold_ok) $display("FAIL bp_hold: got stb=%b cyc=%b data=%h expected 0 1 3000feff", bus.wbm_stb_o, bus.wbm_cyc_o, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (bus.wbm_stb_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0104)
      $display("FAIL bp_next_beat: got stb=%b adr=%h expected 1 30000104", bus.wbm_stb_o, bus.wbm_adr_o); else n_pass++;
    wait_rsp(30, ok);
    n_checks++; if (!ok || rsp_data !== 32'h3000_FEFB || rsp_last !== 1'b1)
      $display("FAIL bp_rsp1: got ok=%b data=%h last=%b expected 1 3000fefb 1", ok, rsp_data, rsp_last); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit extra = 1'b0;
    int base = mon_n;
    int stb_n = 0;
    sl_en     = 1'b0;
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 32'h3000_0200, 4'd2, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      if (bus.wbm_stb_o) stb_n++;
      tick();
    end
    n_checks++; if (!ok || stb_n !== 8) $display("FAIL to_stb_cycles: got ok=%b cycles=%0d expected 1 8", ok, stb_n); else n_pass++;
    n_checks++; if ({rsp_err, rsp_last, rsp_data} !== {2'b11, 32'h0})
      $display("FAIL to_rsp: got err=%b last=%b data=%h expected 1 1 0", rsp_err, rsp_last, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.wbm_stb_o || bus.wbm_cyc_o || busy || rsp_valid) extra = 1'b1;
      tick();
    end
    n_checks++; if (extra || (mon_n - base) !== 0) $display("FAIL to_abort: got activity=%b beats=%0d expected 0 0", extra, mon_n - base); else n_pass++;
    sl_en = 1'b1;
  endtask

  task automatic test_ack_on_limit();
    bit ok;
    int stb_n = 0;
    sl_delay  = 6;
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 32'h3000_0300, 4'd0, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      if (bus.wbm_stb_o) stb_n++;
      tick();
    end
    n_checks++; if (!ok || stb_n !== 8) $display("FAIL lim_stb_cycles: got ok=%b cycles=%0d expected 1 8", ok, stb_n); else n_pass++;
    n_checks++; if ({rsp_err, rsp_last, rsp_data} !== {2'b01, 32'h3000_FCFF})
      $display("FAIL lim_rsp: got err=%b last=%b data=%h expected 0 1 3000fcff", rsp_err, rsp_last, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_addr_wrap();
    bit ok;
    int base = mon_n;
    sl_delay  = 0;
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'hFFFF_FFFC, 4'd1, ok);
    for (int i = 0; i < 30 && busy; i++) tick();
    rsp_ready = 1'b0;
    n_checks++; if ((mon_n - base) !== 2 || mon_adr[base[7:0]] !== 32'hFFFF_FFFC || mon_adr[8'(base + 1)] !== 32'h0)
      $display("FAIL wrap_adr: got beats=%0d adr0=%h adr1=%h expected 2 fffffffc 00000000",
               mon_n - base, mon_adr[base[7:0]], mon_adr[8'(base + 1)]); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit seen = 1'b0;
    int base = mon_n;
    sl_delay  = 3;
    rsp_ready = 1'b1;
    issue_cmd(1'b0, 32'h3000_0400, 4'd3, ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((mon_n - base) == 1 && bus.wbm_stb_o) begin ok = 1'b1; break; end
      tick();
    end
    n_checks++; if (!ok) $display("FAIL rst_reach_beat2: got timeout expected beat 2 strobe"); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, rsp_valid, busy} !== 4'b0)
      $display("FAIL rst_async_release: got cyc/stb/rsp_valid/busy %b expected 0000",
               {bus.wbm_cyc_o, bus.wbm_stb_o, rsp_valid, busy}); else n_pass++;
    rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if ({cmd_ready, busy, rsp_valid} !== 3'b100)
      $display("FAIL rst_recover: got cmd_ready/busy/rsp_valid %b expected 100", {cmd_ready, busy, rsp_valid}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || bus.wbm_cyc_o) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen) $display("FAIL rst_no_rsp: got stale activity expected none"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_backpressure();
    test_timeout();
    test_ack_on_limit();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic-cycle initiator that drives the user-area Wishbone slave port, i.e. the wbs_* interface of wrapper_sha1, from the master side.
- Accepts burst commands plus a write-data stream.
- Issues single-beat classic transfers with auto-incrementing addresses and returns one response per beat.
- Used as the on-chip/bench host for loading and reading the SHA1 engine; includes an ack timeout so a dead slave cannot hang the host.

Parameters:
- TIMEOUT_CYCLES, 255: cycles of stb high without ack before the beat is aborted with error (1..65535).
- LEN_W, 4: width of the burst-length field; a burst is cmd_len+1 beats (max 16 at default).

Ports:
- wb_clk_i  in  1  clock; all logic rising-edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready; high only in IDLE.
- cmd_we  in  1  1=write burst, 0=read burst.
- cmd_adr  in  32  byte address of first beat.
- cmd_sel  in  4  byte selects, applied to every beat.
- cmd_len  in  LEN_W  beats minus one.
- wd_valid  in  1  write data available.
- wd_ready  out  1  write word consumed (pulses on acked write beat).
- wd_data  in  32  write data for the current beat.
- rsp_valid  out  1  beat response available.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  32  read data (0 for writes and errors).
- rsp_err  out  1  beat timed out.
- rsp_last  out  1  final response of the burst.
- busy  out  1  high whenever not IDLE.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - cmd_ready goes to 1 on the first clock after release.
  - State = IDLE; beat counter, timeout counter and address register cleared.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch adr/we/sel/len and set beats_left=cmd_len. Next state is WAIT_WD if we=1, else STROBE. wbm_cyc_o rises in the cycle after accept.
  - WAIT_WD (writes only): cyc=1, stb=0. On wd_valid, load wbm_dat_o=wd_data and go to STROBE.
  - STROBE: cyc=1, stb=1; adr/we/sel/dat stable.
    - ack: capture wbm_dat_i (reads), pulse wd_ready for one cycle (writes), go to RESP with err=0.
    - Timeout counter reaches TIMEOUT_CYCLES with no ack: go to RESP with err=1.
    - If ack arrives in the same cycle the counter hits the limit, ack wins and err=0.
  - RESP: stb=0.
    - rsp_valid=1; rsp_last = (beats_left==0) | err.
    - cyc stays 1 unless rsp_last.
    - Hold until rsp_ready. Response fields are stable while valid&!ready.
    - On handshake: if rsp_last, drop cyc and go to IDLE. Otherwise adr += 4 (mod 2^32, wraps 0xFFFFFFFC->0x00000000), beats_left -= 1, then go to WAIT_WD or STROBE.
- Minimum latency: 1 cycle between stb deassertion and the next beat's stb. A zero-wait slave gives 3 cycles per read beat with rsp_ready held high.
- Timeout counter:
  - Clears on entry to STROBE.
  - Counts only while stb=1.
  - Saturates; cannot wrap.
- Error aborts the burst: remaining beats are not issued and rsp_last=1 on the error response.
- An ack received while stb=0 is ignored.
- wd_valid is ignored outside WAIT_WD; cmd_valid is ignored outside IDLE.
- Reset asserted mid-burst: bus released immediately (cyc/stb 0 asynchronously); pending beats and responses are discarded.

Decomposition:
- Package wb_host_pkg:
  - State enum (IDLE, WAIT_WD, STROBE, RESP).
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, WB_ADR_STEP=4.
- One sub-module, wbm_timeout: saturating counter with clear/enable and an expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Single write, with the slave acking 2 cycles after stb: cmd_we=1, adr=0x3000_0004, sel=0xF, len=0, wd=0xDEADBEEF.
  -> One stb at 0x30000004 with dat=0xDEADBEEF; wd_ready pulses once.
  -> rsp_valid with err=0, last=1; cyc low the cycle after the rsp handshake.
- Read burst: len=3, adr=0x3000_0010, zero-wait slave returning adr^0xFFFF.
  -> Four stb beats at 0x10/0x14/0x18/0x1C; cyc continuous.
  -> rsp_data = 0x3000FFEF, 0x3000FFEB, 0x3000FFE7, 0x3000FFE3; last only on the 4th.
- Backpressure: hold rsp_ready=0 for 5 cycles mid-burst.
  -> stb stays 0, cyc stays 1, rsp_data stable; next beat issues after the handshake.
- Timeout with TIMEOUT_CYCLES=8: slave never acks on a 3-beat read.
  -> stb high exactly 8 cycles; single rsp with err=1, last=1, data=0; no further beats; busy clears.
- Ack arriving exactly on the limit cycle -> err=0, data captured.
- Address wrap: read len=1 at 0xFFFF_FFFC -> second beat address 0x0000_0000.
- Reset pulse during STROBE of beat 2 -> cyc/stb drop asynchronously; after release cmd_ready=1, busy=0, no rsp_valid.
